fifo_wr_arbiter: RTL and testbench

Round-robin arbiter that shares the single write port of the 8x8 FIFO between NREQ producers. Ownership is granted in bursts of up to BURST words and writes are gated by the FIFO `full` flag, so the FIFO never sees a write while full. The block sits between the producer blocks and the FIFO write side. In this use the FIFO `wr_clk` is tied to `clk`.

---
 rtl/fifo_wr_arbiter.sv | 150 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares the write port of the FIFO
// between NREQ producers. Each owner can write up to BURST words. A write only
// happens while the FIFO is not full.
// Optional build macro FIFO_ARB_STATS_EN: adds per-requester counters of
// acknowledged words. The counters are 16 bits wide and saturate.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic              fifo_full,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   ack,
  output logic              fifo_wr,
  output logic [DW-1:0]     fifo_data
`ifdef FIFO_ARB_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [NREQ*16-1:0] stat_count
`endif
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = 4;

  typedef enum logic {IDLE, OWN} state_t;

  state_t          state;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   last;
  logic [CW-1:0]   cnt;

  logic            wr_en;
  logic            release_own;
  logic [IW-1:0]   scan_base;
  logic            win_found;
  logic [IW-1:0]   win_idx;

  logic [DW-1:0]   lane [NREQ];

  // Split the flat data bus into one word per requester
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
      assign lane[gi] = req_data[gi*DW +: DW];
    end
  endgenerate

  // Write qualification and release decision. These use only the registered
  // owner, req and fifo_full. req_data never reaches control.
  always_comb begin
    wr_en       = (state == OWN) && req[owner] && !fifo_full;
    release_own = (state == OWN) &&
                  ((wr_en && (cnt == CW'(BURST - 1))) || !req[owner]);
  end

  // Round-robin scan that starts at base+1 and wraps through base itself.
  // When an owner releases, the scan starts after that owner. In IDLE it
  // starts after the previous owner.
  always_comb begin
    logic [IW-1:0] idx_w;
    int            idx;
    scan_base = (state == OWN) ? owner : last;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    idx_w     = '0;
    // Walk the scan backwards so the nearest candidate is assigned last
    for (int k = NREQ; k >= 1; k--) begin
      idx   = (int'(scan_base) + k) % NREQ;
      idx_w = IW'(idx);
      if (req[idx_w]) begin
        win_found = 1'b1;
        win_idx   = idx_w;
      end
    end
  end

  // Ownership FSM: grant, burst counting, and same-edge handover
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      gnt   <= '0;
      owner <= '0;
      last  <= IW'(NREQ - 1);
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            state <= OWN;
            owner <= win_idx;
            gnt   <= NREQ'(1) << win_idx;
            cnt   <= '0;
          end
        end
        OWN: begin
          if (release_own) begin
            last <= owner;
            cnt  <= '0;
            if (win_found) begin
              owner <= win_idx;
              gnt   <= NREQ'(1) << win_idx;
            end else begin
              state <= IDLE;
              gnt   <= '0;
            end
          end else if (wr_en) begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          gnt   <= '0;
        end
      endcase
    end
  end

  // FIFO write side. ack mirrors the one-hot grant on a write cycle.
  always_comb begin
    fifo_wr   = wr_en;
    ack       = wr_en ? gnt : '0;
    fifo_data = (state == OWN) ? lane[owner] : '0;
  end

`ifdef FIFO_ARB_STATS_EN
  logic [15:0] stat_cnt [NREQ];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
      // Saturating count of acked words. A clear wins over an increment.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          stat_cnt[gi] <= '0;
        end else if (stat_clr) begin
          stat_cnt[gi] <= '0;
        end else if (ack[gi] && (stat_cnt[gi] != 16'hFFFF)) begin
          stat_cnt[gi] <= stat_cnt[gi] + 16'd1;
        end
      end
      assign stat_count[gi*16 +: 16] = stat_cnt[gi];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter with NREQ=4, DW=8 and BURST=4.
// Table rows give the inputs for each cycle and the expected gnt/ack/fifo_wr.
// Expected write data is pushed to a queue when a row is driven and popped
// when the DUT writes. Build with FIFO_ARB_STATS_EN to also test the counters.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        fifo_full;
  logic [3:0]  gnt;
  logic [3:0]  ack;
  logic        fifo_wr;
  logic [7:0]  fifo_data;
`ifdef FIFO_ARB_STATS_EN
  logic        stat_clr;
  logic [63:0] stat_count;
`endif

  int total = 0;
  int bad   = 0;
  int tick  = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       full;
    logic [3:0] gnt;
    logic [3:0] ack;
    logic       wr;
  } vec_t;

  vec_t       vecs[$];
  logic [7:0] exp_q[$];

  fifo_wr_arbiter #(.NREQ(4), .DW(8), .BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .req_data  (req_data),
    .fifo_full (fifo_full),
    .gnt       (gnt),
    .ack       (ack),
    .fifo_wr   (fifo_wr),
    .fifo_data (fifo_data)
`ifdef FIFO_ARB_STATS_EN
    ,
    .stat_clr  (stat_clr),
    .stat_count(stat_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (tick %0d)", name, act, exp, tick);
    end
  endtask

  function automatic void add(input logic r, input logic [3:0] rq, input logic f,
                              input logic [3:0] g, input logic [3:0] a, input logic w);
    vec_t v;
    v.rst = r; v.req = rq; v.full = f; v.gnt = g; v.ack = a; v.wr = w;
    vecs.push_back(v);
  endfunction

  // Each lane carries its index in the high nibble and the cycle number in the low nibble
  task automatic drive_lanes();
    for (int i = 0; i < 4; i++) begin
      req_data[i*8 +: 8] = 8'(i * 16) | 8'(tick % 16);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = '0;
    fifo_full = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  function automatic int onehot_idx(input logic [3:0] v);
    int r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  initial begin
    logic [7:0] expd;
    // Single requester: 4-word burst, same-edge regrant, then 2 more words
    add(1, 4'b0001, 0, 4'b0000, 4'b0000, 0);
    for (int i = 0; i < 6; i++) add(0, 4'b0001, 0, 4'b0001, 4'b0001, 1);
    add(0, 4'b0000, 0, 4'b0001, 4'b0000, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    // All four requesting: order 0,1,2,3,0 with 4 words each and no gaps
    add(1, 4'b1111, 0, 4'b0000, 4'b0000, 0);
    for (int o = 0; o < 4; o++)
      for (int i = 0; i < 4; i++)
        add(0, 4'b1111, 0, 4'(1 << o), 4'(1 << o), 1);
    add(0, 4'b1111, 0, 4'b0001, 4'b0001, 1);
    add(0, 4'b0000, 0, 4'b0001, 4'b0000, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    // Full stall for 3 cycles after 2 writes by owner 1
    add(1, 4'b0010, 0, 4'b0000, 4'b0000, 0);
    for (int i = 0; i < 2; i++) add(0, 4'b0010, 0, 4'b0010, 4'b0010, 1);
    for (int i = 0; i < 3; i++) add(0, 4'b0010, 1, 4'b0010, 4'b0000, 0);
    for (int i = 0; i < 2; i++) add(0, 4'b0010, 0, 4'b0010, 4'b0010, 1);
    add(0, 4'b0000, 0, 4'b0010, 4'b0000, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 0);
    // Owner 2 drops after one word with 0 and 3 pending: next is 3, then 0
    add(1, 4'b0100, 0, 4'b0000, 4'b0000, 0);
    add(0, 4'b1101, 0, 4'b0100, 4'b0100, 1);
    add(0, 4'b1001, 0, 4'b0100, 4'b0000, 0);
    add(0, 4'b1001, 0, 4'b1000, 4'b1000, 1);
    add(0, 4'b0001, 0, 4'b1000, 4'b0000, 0);
    add(0, 4'b0001, 0, 4'b0001, 4'b0001, 1);
    add(0, 4'b0000, 0, 4'b0001, 4'b0000, 0);
    add(0, 4'b0000, 0, 4'b0000, 4'b0000, 0);

    reset     = 1'b1;
    req       = '0;
    fifo_full = 1'b0;
    req_data  = '0;
`ifdef FIFO_ARB_STATS_EN
    stat_clr  = 1'b0;
`endif
    // Outputs while reset is asserted, before any clock edge
    #2;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_wr", 32'(fifo_wr), 32'h0);
    chk("rst_data", 32'(fifo_data), 32'h0);

    foreach (vecs[n]) begin
      if (vecs[n].rst) begin
        if (exp_q.size() != 0) chk("queue_left", 32'(exp_q.size()), 32'h0);
        exp_q.delete();
        do_reset();
      end
      @(posedge clk);
      #1;
      tick++;
      req       = vecs[n].req;
      fifo_full = vecs[n].full;
      drive_lanes();
      if (vecs[n].wr) exp_q.push_back(8'(onehot_idx(vecs[n].ack) * 16) | 8'(tick % 16));
      @(negedge clk);
      $display("row %0d: req=%b full=%b gnt=%b ack=%b wr=%b data=%h", n, req, fifo_full, gnt, ack, fifo_wr, fifo_data);
      chk("gnt", 32'(gnt), 32'(vecs[n].gnt));
      chk("ack", 32'(ack), 32'(vecs[n].ack));
      chk("fifo_wr", 32'(fifo_wr), 32'(vecs[n].wr));
      if (fifo_wr === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wr", 32'(fifo_data), 32'hFFFF_FFFF);
        end else begin
          expd = exp_q.pop_front();
          chk("fifo_data", 32'(fifo_data), 32'(expd));
        end
      end
      if (vecs[n].gnt == 4'b0000) chk("idle_data", 32'(fifo_data), 32'h0);
    end
    chk("queue_end", 32'(exp_q.size()), 32'h0);

    // Asynchronous reset during a write: outputs clear without a clock edge
    do_reset();
    @(posedge clk);
    #1;
    tick++;
    req = 4'b1111;
    drive_lanes();
    @(posedge clk);
    #1;
    tick++;
    drive_lanes();
    @(negedge clk);
    chk("mid_wr_before", 32'(fifo_wr), 32'h1);
    #1 reset = 1'b1;
    #1;
    $display("async reset: gnt=%b ack=%b wr=%b data=%h", gnt, ack, fifo_wr, fifo_data);
    chk("async_gnt", 32'(gnt), 32'h0);
    chk("async_ack", 32'(ack), 32'h0);
    chk("async_wr", 32'(fifo_wr), 32'h0);
    chk("async_data", 32'(fifo_data), 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("post_rst_idle", 32'(gnt), 32'h0);
    @(negedge clk);
    $display("after reset release: gnt=%b wr=%b", gnt, fifo_wr);
    chk("post_rst_first", 32'(gnt), 32'h1);
    chk("post_rst_ack", 32'(ack), 32'h1);

`ifdef FIFO_ARB_STATS_EN
    // Saturating counter on lane 1, then a clear
    do_reset();
    @(posedge clk);
    #1 req = 4'b0010;
    for (int i = 0; i < 70010; i++) begin
      @(posedge clk);
    end
    #1 req = 4'b0000;
    @(posedge clk);
    @(posedge clk);
    #1;
    $display("stats: lane0=%h lane1=%h lane2=%h lane3=%h", stat_count[15:0], stat_count[31:16], stat_count[47:32], stat_count[63:48]);
    chk("stat_sat1", 32'(stat_count[31:16]), 32'hFFFF);
    chk("stat_lane0", 32'(stat_count[15:0]), 32'h0);
    chk("stat_lane2", 32'(stat_count[47:32]), 32'h0);
    chk("stat_lane3", 32'(stat_count[63:48]), 32'h0);
    stat_clr = 1'b1;
    @(posedge clk);
    #1 stat_clr = 1'b0;
    $display("stats after clear: lane1=%h", stat_count[31:16]);
    chk("stat_clr1", 32'(stat_count[31:16]), 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
